// File: rtl/count_display_pkg.sv
// Shared constants for the count display driver: conversion FSM states,
// seven-segment patterns (active-low {g,f,e,d,c,b,a}) and the blank code.
package count_display_pkg;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    // Any nibble above 9 decodes to an unlit digit; this one is used on purpose.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [3:0] bcd_adjust(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low seven-segment pattern.
module seg7_decoder
    import count_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display_driver.sv
// Binary count to multiplexed decimal display: double-dabble conversion FSM
// feeding committed digit registers, scanned one digit per refresh tick.
//
//   state      | meaning
//   CONV_IDLE  | sample Count, clear BCD scratch
//   CONV_SHIFT | WIDTH add-3/shift steps of {bcd, bin}
//   CONV_DONE  | commit BCD scratch to digit registers, pulse Conv_done
module count_display_driver
    import count_display_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  Count,
    output logic [6:0]        Seg,
    output logic [DIGITS-1:0] An,
    output logic              Conv_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    conv_state_t         state, state_nxt;
    logic [CNT_W-1:0]    shift_cnt;
    logic [WIDTH-1:0]    bin_sr;
    logic [4*DIGITS-1:0] bcd_sr;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] digit_reg;

    logic [PRE_W-1:0]    pre_cnt;
    logic                scan_tick;
    logic [IDX_W-1:0]    digit_idx, idx_nxt;
    logic [DIGITS-1:0]   blank_mask;
    logic [3:0]          sel_nibble;
    logic [6:0]          seg_dec;

    always_ff @(posedge Clk) begin
        if (!reset) state <= CONV_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE:  state_nxt = CONV_SHIFT;
            CONV_SHIFT: if (shift_cnt == '0) state_nxt = CONV_DONE;
            CONV_DONE:  state_nxt = CONV_IDLE;
            default:    state_nxt = CONV_IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < DIGITS; i++)
            bcd_adj[4*i +: 4] = bcd_adjust(bcd_sr[4*i +: 4]);
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            bin_sr    <= '0;
            bcd_sr    <= '0;
            shift_cnt <= '0;
            digit_reg <= '0;
            Conv_done <= 1'b0;
        end else begin
            Conv_done <= 1'b0;
            case (state)
                CONV_IDLE: begin
                    bin_sr    <= Count;
                    bcd_sr    <= '0;
                    shift_cnt <= CNT_W'(WIDTH - 1);
                end
                CONV_SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    shift_cnt        <= shift_cnt - CNT_W'(1);
                end
                CONV_DONE: begin
                    digit_reg <= bcd_sr;
                    Conv_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign scan_tick = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
    assign idx_nxt   = (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);

    // A digit is blanked when it and every digit above it are zero; units never.
    always_comb begin
        logic zero_run;
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run      = zero_run & (digit_reg[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_run;
        end
    end

    always_comb begin
        sel_nibble = BLANK_CODE;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i))
                sel_nibble = blank_mask[i] ? BLANK_CODE : digit_reg[4*i +: 4];
        end
    end

    seg7_decoder u_seg7_decoder (
        .digit (sel_nibble),
        .seg   (seg_dec)
    );

    always_ff @(posedge Clk) begin
        if (!reset) begin
            pre_cnt   <= '0;
            digit_idx <= '0;
            An        <= '1;
            Seg       <= SEG_BLANK;
        end else if (scan_tick) begin
            pre_cnt   <= '0;
            digit_idx <= idx_nxt;
            An        <= ~(DIGITS'(1) << idx_nxt);
            Seg       <= seg_dec;
        end else begin
            pre_cnt   <= pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver: vector table, hand-written corner sequences
// and random Count/reset traffic against a decimal-arithmetic display model.
module tb_count_display_driver;

    localparam int W  = 5;
    localparam int D  = 2;
    localparam int RD = 4;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic         Clk = 1'b0;
    logic         reset;
    logic [W-1:0] Count;
    logic [6:0]   Seg;
    logic [D-1:0] An;
    logic         Conv_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    count_display_driver #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(RD)) dut (
        .Clk       (Clk),
        .reset     (reset),
        .Count     (Count),
        .Seg       (Seg),
        .An        (An),
        .Conv_done (Conv_done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] expect_seg(input int val, input int slot);
        int p;
        p = 1;
        for (int i = 0; i < slot; i++) p = p * 10;
        if (slot > 0 && val < p) return BLANK;
        return seg_tab[(val / p) % 10];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion is sampled every W+2 cycles from reset release
    // and committed W+1 cycles later; the display scans one slot per RD cycles.
    int         phase, pending, disp_val, pre, idx;
    logic       m_done;
    logic [1:0] m_an;
    logic [6:0] m_seg;

    always @(posedge Clk) begin
        if (!reset) begin
            phase <= 0; pending <= 0; disp_val <= 0; pre <= 0; idx <= 0;
            m_done <= 1'b0; m_an <= 2'b11; m_seg <= BLANK;
        end else begin
            if (pre == RD - 1) begin
                pre   <= 0;
                idx   <= (idx + 1) % D;
                m_an  <= ~(2'(1) << ((idx + 1) % D));
                m_seg <= expect_seg(disp_val, (idx + 1) % D);
            end else begin
                pre <= pre + 1;
            end
            if (phase == 0) pending <= int'(Count);
            if (phase == W + 1) disp_val <= pending;
            m_done <= (phase == W + 1);
            phase  <= (phase == W + 1) ? 0 : phase + 1;
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                check("model_seg", 16'(Seg), 16'(m_seg));
                check("model_an", 16'(An), 16'(m_an));
                check("model_done", 16'(Conv_done), 16'(m_done));
            end
        end
    end

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            @(negedge Clk);
            if (Conv_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({name, "_timeout"}, 16'd0, 16'd1);
    endtask

    task automatic observe(input int cycles, output logic [6:0] units, output logic [6:0] tens);
        units = 7'bx;
        tens  = 7'bx;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (An == 2'b10) units = Seg;
            if (An == 2'b01) tens  = Seg;
        end
    endtask

    task automatic measure_latency(input string name, input int exp_lat);
        int lat;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (Conv_done && lat < 0) lat = k;
        end
        check(name, 16'(lat), 16'(exp_lat));
    endtask

    typedef struct {
        int         count;
        logic [6:0] units;
        logic [6:0] tens;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [6:0] u, t;
        logic [1:0] an_prev;
        bit         moved;

        vecs[0] = '{23, 7'b0110000, 7'b0100100};
        vecs[1] = '{31, 7'b1111001, 7'b0110000};
        vecs[2] = '{0,  7'b1000000, 7'b1111111};
        vecs[3] = '{7,  7'b1111000, 7'b1111111};
        vecs[4] = '{10, 7'b1000000, 7'b1111001};
        vecs[5] = '{19, 7'b0010000, 7'b1111001};
        vecs[6] = '{9,  7'b0010000, 7'b1111111};

        reset = 1'b0;
        Count = '0;
        @(posedge Clk);
        #1 chk_en = 1'b1;

        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("rst_an", 16'(An), 16'(2'b11));
            check("rst_seg", 16'(Seg), 16'(BLANK));
            check("rst_done", 16'(Conv_done), 16'd0);
        end

        Count = 5'd23;
        reset = 1'b1;
        measure_latency("latency_23", W + 1);

        foreach (vecs[v]) begin
            Count = W'(vecs[v].count);
            wait_done("vec");
            wait_done("vec");
            wait_done("vec");
            observe(3 * RD, u, t);
            check($sformatf("vec%0d_units", vecs[v].count), 16'(u), 16'(vecs[v].units));
            check($sformatf("vec%0d_tens", vecs[v].count), 16'(t), 16'(vecs[v].tens));
        end

        // Count changes on the second SHIFT cycle: that conversion keeps 23.
        Count = 5'd23;
        wait_done("seq31");
        wait_done("seq31");
        @(negedge Clk);
        @(negedge Clk);
        Count = 5'd9;
        wait_done("seq31_a");
        an_prev = An;
        moved = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge Clk);
            if (An != an_prev) begin
                moved = 1'b1;
                check("midshift_keep23", 16'(Seg), 16'(expect_seg(23, (An == 2'b01) ? 1 : 0)));
                break;
            end
        end
        if (!moved) check("midshift_tick_timeout", 16'd0, 16'd1);
        wait_done("seq31_b");
        observe(3 * RD, u, t);
        check("next_conv_units9", 16'(u), 16'(seg_tab[9]));
        check("next_conv_tens_blank", 16'(t), 16'(BLANK));

        // Reset during SHIFT aborts the conversion.
        Count = 5'd31;
        wait_done("seq32");
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            check("abort_no_done", 16'(Conv_done), 16'd0);
            check("abort_an", 16'(An), 16'(2'b11));
            check("abort_seg", 16'(Seg), 16'(BLANK));
        end
        reset = 1'b1;
        measure_latency("restart_latency", W + 1);
        observe(3 * RD, u, t);
        check("restart_units", 16'(u), 16'(seg_tab[1]));
        check("restart_tens", 16'(t), 16'(seg_tab[3]));

        for (int c = 0; c < 1500; c++) begin
            @(negedge Clk);
            if ($urandom_range(0, 7) == 0) Count = W'($urandom_range(0, 31));
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge Clk);
                reset = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
